// File: rtl/xcore_if_gshare_if.sv
// Bus bundle for the xcore_if_gshare branch predictor: fetch PC, BTB
// response, prediction outputs and write-back commit. The slave modport is
// the predictor's view; the master modport is the fetch/commit side.
interface xcore_if_gshare_if #(
  parameter int ILEN = 7
);
  // Pre-IF fetch request
  logic [31:0]     i_pref_pc;
  logic            i_pref_valid;
  logic            i_pref_stall;
  // BTB response, one cycle after i_pref_pc
  logic            i_btb_hit;
  logic [2:0]      i_btb_type;
  logic [31:0]     i_btb_target;
  // Prediction for the PC presented the previous cycle
  logic            o_bpu_valid;
  logic [31:0]     o_bpu_pc;
  logic            o_bpu_taken;
  logic [31:0]     o_bpu_npc;
  logic [ILEN-1:0] o_bpu_idx;
  // Write-back commit of a resolved branch
  logic            i_wb_cmt_req;
  logic            i_wb_cmt_branch;
  logic            i_wb_cmt_taken;
  logic [ILEN-1:0] i_wb_cmt_idx;

  modport slave (
    input  i_pref_pc, i_pref_valid, i_pref_stall,
    input  i_btb_hit, i_btb_type, i_btb_target,
    output o_bpu_valid, o_bpu_pc, o_bpu_taken, o_bpu_npc, o_bpu_idx,
    input  i_wb_cmt_req, i_wb_cmt_branch, i_wb_cmt_taken, i_wb_cmt_idx
  );

  modport master (
    output i_pref_pc, i_pref_valid, i_pref_stall,
    output i_btb_hit, i_btb_type, i_btb_target,
    input  o_bpu_valid, o_bpu_pc, o_bpu_taken, o_bpu_npc, o_bpu_idx,
    output i_wb_cmt_req, i_wb_cmt_branch, i_wb_cmt_taken, i_wb_cmt_idx
  );
endinterface

// File: rtl/xcore_if_gshare.sv
// Direction predictor for the instruction-fetch stage. A table of 2-bit
// saturating counters (PHT) is read with the pre-IF PC so its counter lines
// up with the registered BTB outputs one cycle later; the final taken/next-PC
// decision merges the two. Counters and history are trained only at commit.
//
// Build option: define XCORE_BPU_GSHARE_EN for G-share indexing (PC bits XOR
// global history). Without it the predictor is bimodal (PC bits only) and no
// history register exists.
module xcore_if_gshare #(
  parameter int ENTRY_NUM = 128,
  parameter int GHR_LEN   = $clog2(ENTRY_NUM)
) (
  input logic               i_sys_clk,
  input logic               i_sys_rst,
  xcore_if_gshare_if.slave  bus
);

  localparam int ILEN = $clog2(ENTRY_NUM);

  localparam logic [2:0] BTB_BRANCH = 3'b100;
  localparam logic [2:0] BTB_JAL    = 3'b010;
  localparam logic [2:0] BTB_JALR   = 3'b001;

  // Pattern history table and prediction-stage registers
  logic [1:0]      r_pht [ENTRY_NUM];
  logic            r_valid;
  logic [31:0]     r_pc;
  logic [ILEN-1:0] r_idx;
  logic [1:0]      r_cnt;

  logic [ILEN-1:0] w_rd_idx;
  logic            w_cmt_upd;
  logic            w_taken;
  logic            w_unused;

  assign w_cmt_upd = bus.i_wb_cmt_req & bus.i_wb_cmt_branch;

`ifdef XCORE_BPU_GSHARE_EN
  logic [GHR_LEN-1:0] r_ghr;
  logic [ILEN-1:0]    w_ghr_ext;

  // Zero-extend the history to the index width (history may be shorter)
  always_comb begin
    w_ghr_ext               = '0;
    w_ghr_ext[GHR_LEN-1:0]  = r_ghr;
  end

  assign w_rd_idx = bus.i_pref_pc[ILEN+1:2] ^ w_ghr_ext;

  // Global history: shift in the resolved direction of each committed branch
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_ghr <= '0;
    end else if (w_cmt_upd) begin
      r_ghr <= (r_ghr << 1) | GHR_LEN'(bus.i_wb_cmt_taken);
    end
  end
`else
  assign w_rd_idx = bus.i_pref_pc[ILEN+1:2];
`endif

  // PC bits outside the index field do not take part in the lookup
  assign w_unused = ^{bus.i_pref_pc[31:ILEN+2], bus.i_pref_pc[1:0]};

  // Train the addressed counter on each committed conditional branch
  // NOTE: the PHT is built from flops rather than RAM because every counter
  // must come out of reset at weakly-not-taken (01); a RAM macro could not
  // be cleared asynchronously.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        r_pht[i] <= 2'b01;
      end
    end else if (w_cmt_upd) begin
      if (bus.i_wb_cmt_taken) begin
        if (r_pht[bus.i_wb_cmt_idx] != 2'b11) begin
          r_pht[bus.i_wb_cmt_idx] <= r_pht[bus.i_wb_cmt_idx] + 2'd1;
        end
      end else begin
        if (r_pht[bus.i_wb_cmt_idx] != 2'b00) begin
          r_pht[bus.i_wb_cmt_idx] <= r_pht[bus.i_wb_cmt_idx] - 2'd1;
        end
      end
    end
  end

  // Capture the looked-up counter with its PC so it meets the BTB response
  // NOTE: non-blocking assignment here means a same-cycle commit to the same
  // entry is seen by the next read, while this read captures the old value.
  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (!bus.i_pref_stall) begin
      r_valid <= bus.i_pref_valid;
      r_pc    <= bus.i_pref_pc;
      r_idx   <= w_rd_idx;
      r_cnt   <= r_pht[w_rd_idx];
    end
  end

  // Final direction: jumps always taken, branches follow the counter MSB
  // NOTE: every output of this block is assigned on every path, so no latch
  // is inferred even though the taken term is a nested condition.
  always_comb begin
    w_taken = 1'b0;
    if (r_valid && bus.i_btb_hit) begin
      case (bus.i_btb_type)
        BTB_JAL, BTB_JALR: w_taken = 1'b1;
        BTB_BRANCH:        w_taken = r_cnt[1];
        default:           w_taken = 1'b0;
      endcase
    end
  end

  assign bus.o_bpu_valid = r_valid;
  assign bus.o_bpu_pc    = r_pc;
  assign bus.o_bpu_idx   = r_idx;
  assign bus.o_bpu_taken = w_taken;
  assign bus.o_bpu_npc   = w_taken ? bus.i_btb_target : (r_pc + 32'd4);

endmodule
